// File: rtl/mult_arb_pkg.sv
// Shared types and constants for the mult32x32 arbiter and its multiplier.
package mult_arb_pkg;

  localparam int OPER_W    = 32;
  localparam int PROD_W    = 64;
  localparam int N_REQ_MAX = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_DONE
  } state_e;

endpackage

// File: rtl/mult32x32.sv
// Shared unsigned 32x32->64 shift-add multiplier. A start pulse while idle
// raises busy on the next edge; busy stays high for 32 iterations and the
// product is final when busy drops. Synchronous active-high reset.
module mult32x32
  import mult_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [OPER_W-1:0] a,
  input  logic [OPER_W-1:0] b,
  output logic              busy,
  output logic [PROD_W-1:0] product
);

  logic              busy_q, busy_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [PROD_W-1:0] acc_q, acc_d;
  logic [PROD_W-1:0] mcand_q, mcand_d;
  logic [OPER_W-1:0] mplier_q, mplier_d;

  // one multiplier bit per cycle; down-counter ends the run at terminal count
  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (!busy_q) begin
      if (start) begin
        busy_d   = 1'b1;
        cnt_d    = 6'd32;
        acc_d    = '0;
        mcand_d  = {{(PROD_W-OPER_W){1'b0}}, a};
        mplier_d = b;
      end
    end else begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - 6'd1;
      if (cnt_q == 6'd1) begin
        busy_d = 1'b0;
      end
    end
  end

  // datapath and control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  assign busy    = busy_q;
  assign product = acc_q;

endmodule

// File: rtl/mult_arb_pick.sv
// Combinational grant selector: first asserted request found when scanning
// upward (with wrap) from ptr. Tie ptr to zero for fixed lowest-index priority.
module mult_arb_pick #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt_oh,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_any
);

  logic [IDX_W:0] cand;

  // rotate-and-scan search starting at the pointer
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N_REQ)) begin
        cand = cand - (IDX_W+1)'(N_REQ);
      end
      if (!gnt_any && req[cand[IDX_W-1:0]]) begin
        gnt_any                 = 1'b1;
        gnt_idx                 = cand[IDX_W-1:0];
        gnt_oh[cand[IDX_W-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult32x32_arb.sv
// Arbiter sharing one mult32x32 among N_REQ requesters.
// Build option MULT_ARB_RR_EN: round-robin grant with a rotating pointer;
// when undefined, fixed priority (lowest index wins) and no pointer register.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for any req_valid; grant and latch operands on exit
// ST_START   | mul_start high, req_ready pulses to the granted requester
// ST_WAIT_HI | waiting for the multiplier to raise busy
// ST_WAIT_LO | waiting for busy to drop; capture product on exit
// ST_DONE    | rsp_valid pulses to the granted requester
module mult32x32_arb
  import mult_arb_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*OPER_W-1:0] req_a,
  input  logic [N_REQ*OPER_W-1:0] req_b,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [PROD_W-1:0]       rsp_product,
  output logic                    mul_start,
  output logic [OPER_W-1:0]       mul_a,
  output logic [OPER_W-1:0]       mul_b,
  input  logic                    mul_busy,
  input  logic [PROD_W-1:0]       mul_product
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  grant_oh_q, grant_oh_d;
  logic [OPER_W-1:0] mul_a_q, mul_a_d;
  logic [OPER_W-1:0] mul_b_q, mul_b_d;
  logic [PROD_W-1:0] rsp_product_q, rsp_product_d;

  logic [N_REQ-1:0]  pick_oh;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;
  logic [IDX_W-1:0]  pick_ptr;

  logic [OPER_W-1:0] req_a_arr [N_REQ];
  logic [OPER_W-1:0] req_b_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign req_a_arr[g] = req_a[g*OPER_W +: OPER_W];
    assign req_b_arr[g] = req_b[g*OPER_W +: OPER_W];
  end

`ifdef MULT_ARB_RR_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;
  assign pick_ptr = ptr_q;
`else
  assign pick_ptr = '0;
`endif

  mult_arb_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req     (req_valid),
    .ptr     (pick_ptr),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .gnt_any (pick_any)
  );

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      grant_oh_q    <= '0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      rsp_product_q <= '0;
`ifdef MULT_ARB_RR_EN
      ptr_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      grant_oh_q    <= grant_oh_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      rsp_product_q <= rsp_product_d;
`ifdef MULT_ARB_RR_EN
      ptr_q         <= ptr_d;
`endif
    end
  end

  // next state; operands only load in IDLE so they hold through the run
  always_comb begin
    state_d       = state_q;
    grant_oh_d    = grant_oh_q;
    mul_a_d       = mul_a_q;
    mul_b_d       = mul_b_q;
    rsp_product_d = rsp_product_q;
`ifdef MULT_ARB_RR_EN
    ptr_d         = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d    = ST_START;
          grant_oh_d = pick_oh;
          mul_a_d    = req_a_arr[pick_idx];
          mul_b_d    = req_b_arr[pick_idx];
`ifdef MULT_ARB_RR_EN
          ptr_d      = (pick_idx == IDX_W'(N_REQ-1)) ? '0 : pick_idx + IDX_W'(1);
`endif
        end
      end
      ST_START:   state_d = ST_WAIT_HI;
      ST_WAIT_HI: if (mul_busy) state_d = ST_WAIT_LO;
      ST_WAIT_LO: begin
        if (!mul_busy) begin
          rsp_product_d = mul_product;
          state_d       = ST_DONE;
        end
      end
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // state-decoded pulses, steered by the latched one-hot grant
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    mul_start = 1'b0;
    case (state_q)
      ST_START: begin
        req_ready = grant_oh_q;
        mul_start = 1'b1;
      end
      ST_DONE:  rsp_valid = grant_oh_q;
      default:  ;
    endcase
  end

  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign rsp_product = rsp_product_q;

endmodule
